// File: rtl/button_press_classifier.sv
// Turns the debounced, active-low button level into single-cycle key events:
// short press, long press and auto-repeat ticks, plus a count of completed presses.
module button_press_classifier #(
    parameter int LONG_CYCLES   = 50,
    parameter int REPEAT_CYCLES = 10,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Din,
    output logic             pressed,
    output logic             short_press,
    output logic             long_press,
    output logic             repeat_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int HOLD_W    = $clog2(LONG_CYCLES);
    localparam int REP_W     = (REPEAT_CYCLES < 2) ? 1 : $clog2(REPEAT_CYCLES);
    localparam int HOLD_LAST = LONG_CYCLES - 1;
    localparam int REP_LAST  = (REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1;

    typedef enum logic [1:0] {
        WAIT_REL  = 2'd0,
        IDLE      = 2'd1,
        HELD      = 2'd2,
        LONG_HELD = 2'd3
    } state_t;

    // state is kept as a named register so checkers can bind to it directly.
    state_t            state;
    logic              din_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            // din_q resets to "pressed" so a button held through reset is ignored until released.
            din_q        <= 1'b0;
            state        <= WAIT_REL;
            hold_cnt     <= '0;
            rep_cnt      <= '0;
            pressed      <= 1'b0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            press_count  <= '0;
        end else begin
            din_q        <= Din;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;

            case (state)
                WAIT_REL: begin
                    if (din_q) state <= IDLE;
                end
                IDLE: begin
                    if (!din_q) begin
                        state    <= HELD;
                        hold_cnt <= HOLD_W'(1);
                        pressed  <= 1'b1;
                    end
                end
                HELD: begin
                    // Release is checked first so it wins on the threshold edge.
                    if (din_q) begin
                        state       <= IDLE;
                        short_press <= 1'b1;
                        press_count <= press_count + 1'b1;
                        pressed     <= 1'b0;
                    end else if (hold_cnt == HOLD_W'(HOLD_LAST)) begin
                        state      <= LONG_HELD;
                        long_press <= 1'b1;
                        rep_cnt    <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (din_q) begin
                        state       <= IDLE;
                        press_count <= press_count + 1'b1;
                        pressed     <= 1'b0;
                    end else if (REPEAT_CYCLES != 0) begin
                        if (rep_cnt == REP_W'(REP_LAST)) begin
                            repeat_pulse <= 1'b1;
                            rep_cnt      <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                end
                default: state <= WAIT_REL;
            endcase
        end
    end

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier: per-edge expected output vectors are derived from
// the press length and pushed to a scoreboard queue, then compared after each edge.
module tb_button_press_classifier;

    localparam int L = 8;
    localparam int R = 3;
    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         din;
    logic         pressed;
    logic         short_press;
    logic         long_press;
    logic         repeat_pulse;
    logic [W-1:0] press_count;

    logic [7:0]   exp_q[$];
    logic [W-1:0] exp_count;
    int           checks;
    int           errors;

    button_press_classifier #(
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(R),
        .CNT_W        (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Din         (din),
        .pressed     (pressed),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse),
        .press_count (press_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b (pressed,short,long,repeat,count)", tag, got, exp);
        end
    endtask

    // Expected outputs after relative edge e of a press of n zero samples, where edge 0
    // is the first edge sampling Din=0 from IDLE.
    function automatic logic [7:0] exp_vec(input int e, input int n, input logic [W-1:0] base);
        logic         p, s, lg, rp;
        logic [W-1:0] c;
        p  = (e >= 1) && (e <= n);
        s  = (e == n + 1) && (n < L);
        lg = (e == L) && (n >= L);
        rp = (n >= L) && (e > L) && (e <= n) && (((e - L) % R) == 0);
        c  = (e >= n + 1) ? base + 1'b1 : base;
        return {p, s, lg, rp, c};
    endfunction

    // driver: apply inputs, push expectation, take one edge, pop and compare
    task automatic tick(input logic rst_v, input logic din_v, input logic [7:0] exp, input string tag);
        logic [7:0] e;
        reset = rst_v;
        din   = din_v;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, {pressed, short_press, long_press, repeat_pulse, press_count}, e);
    endtask

    task automatic idle_cycles(input int n, input logic din_v, input string tag);
        for (int i = 0; i < n; i++)
            tick(1'b0, din_v, {4'b0000, exp_count}, $sformatf("%s_c%0d", tag, i));
    endtask

    task automatic do_reset(input logic din_v, input string tag);
        exp_count = '0;
        tick(1'b1, din_v, 8'h00, tag);
    endtask

    // Full press: n cycles low then h (>=2) cycles high; leaves the FSM in IDLE.
    task automatic press(input int n, input int h, input string tag);
        for (int e = 0; e < n + h; e++)
            tick(1'b0, (e < n) ? 1'b0 : 1'b1, exp_vec(e, n, exp_count),
                 $sformatf("%s_n%0d_e%0d", tag, n, e));
        exp_count = exp_count + 1'b1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_count = '0;
        reset     = 1'b1;
        din       = 1'b1;

        // reset state, then arm (WAIT_REL needs din_q=1 before reaching IDLE)
        do_reset(1'b1, "reset");
        idle_cycles(3, 1'b1, "arm");

        // 1: short press of 3 cycles
        press(3, 2, "t1");

        // 2: long hold with repeats at edges 11,14,17,20
        press(20, 2, "t2");

        // 3: threshold boundary: release seen on the threshold edge vs one cycle later
        press(L - 1, 2, "t3a");
        press(L, 2, "t3b");

        // 4: button held through reset produces nothing until released
        do_reset(1'b0, "t4_rst");
        idle_cycles(10, 1'b0, "t4_held");
        idle_cycles(3, 1'b1, "t4_rel");
        press(2, 2, "t4");

        // 5: counter wrap over 17 short presses
        do_reset(1'b1, "t5_rst");
        idle_cycles(3, 1'b1, "t5_arm");
        for (int i = 0; i < 17; i++) press(1, 2, $sformatf("t5_%0d", i));

        // 6: reset in the middle of a held press
        for (int e = 0; e < 5; e++)
            tick(1'b0, 1'b0, exp_vec(e, 1000, exp_count), $sformatf("t6_e%0d", e));
        do_reset(1'b0, "t6_rst");
        idle_cycles(4, 1'b0, "t6_held");
        idle_cycles(3, 1'b1, "t6_rel");
        press(3, 2, "t6");

        // random press lengths around the thresholds
        for (int i = 0; i < 8; i++) press($urandom_range(1, 16), $urandom_range(2, 4), $sformatf("rnd%0d", i));

        check("q_empty", 8'(exp_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
